// File: rtl/divider.sv
// rtl/divider.sv - angle range reduction: data_in mod 360 plus quadrant, one-cycle latency
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous reset, active HIGH despite the name
//   en_divider  operand valid; data_in is captured on the rising edge when 1
//   data_in     unsigned angle in degrees
//   data_out    data_in mod MODULUS, zero-extended
//   quadrant    reduced angle / QUAD_SIZE (0..3)
//   valid_out   one-cycle pulse marking a freshly computed result
module divider #(
  parameter int DATA_WIDTH = 32,
  parameter int MODULUS    = 360,
  parameter int QUAD_SIZE  = 90
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_divider,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            quadrant,
  output logic                  valid_out
);

  // Partial remainder width: enough to hold 0..MODULUS-1.
  localparam int REM_W = $clog2(MODULUS);

  localparam logic [REM_W:0]   MOD_T = (REM_W+1)'(MODULUS);
  localparam logic [REM_W-1:0] Q1_T  = REM_W'(QUAD_SIZE);
  localparam logic [REM_W-1:0] Q2_T  = REM_W'(2 * QUAD_SIZE);
  localparam logic [REM_W-1:0] Q3_T  = REM_W'(3 * QUAD_SIZE);

  logic [REM_W-1:0] rem;
  logic [1:0]       quad;

  logic [REM_W-1:0] rem_q;
  logic [1:0]       quad_q;
  logic             valid_q;

  // Unrolled restoring division by the constant modulus, MSB first.
  // The partial remainder is always < MODULUS, so after shifting in one
  // dividend bit it fits in REM_W+1 bits and at most one subtraction
  // restores it to range. The quotient bits are not needed.
  always_comb begin
    logic [REM_W-1:0] pr;
    logic [REM_W:0]   trial;
    logic [REM_W:0]   diff;
    pr    = '0;
    trial = '0;
    diff  = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      trial = {pr, data_in[i]};
      diff  = trial - MOD_T;
      if (trial >= MOD_T) begin
        pr = diff[REM_W-1:0];
      end else begin
        pr = trial[REM_W-1:0];
      end
    end
    rem = pr;
  end

  // Quadrant from three threshold compares on the reduced angle.
  always_comb begin
    quad = 2'd0;
    if (rem >= Q3_T) begin
      quad = 2'd3;
    end else if (rem >= Q2_T) begin
      quad = 2'd2;
    end else if (rem >= Q1_T) begin
      quad = 2'd1;
    end
  end

  // Result registers. Reset wins over enable; with enable low the data
  // holds and only the valid pulse drops.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rem_q   <= '0;
      quad_q  <= 2'd0;
      valid_q <= 1'b0;
    end else if (en_divider) begin
      rem_q   <= rem;
      quad_q  <= quad;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign data_out  = {{(DATA_WIDTH - REM_W){1'b0}}, rem_q};
  assign quadrant  = quad_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against an arithmetic model
module tb_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en_divider = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [1:0]  quadrant;
  logic        valid_out;

  int vectors = 0;
  int miscompares = 0;
  bit check_on = 1'b0;

  // Reference model: plain modulo/divide arithmetic, one register stage.
  logic [31:0] exp_data = '0;
  logic [1:0]  exp_quad = '0;
  logic        exp_valid = 1'b0;

  divider #(.DATA_WIDTH(32), .MODULUS(360), .QUAD_SIZE(90)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_divider (en_divider),
    .data_in    (data_in),
    .data_out   (data_out),
    .quadrant   (quadrant),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n) begin
      exp_data  <= 32'd0;
      exp_quad  <= 2'd0;
      exp_valid <= 1'b0;
    end else if (en_divider) begin
      exp_data  <= data_in % 32'd360;
      exp_quad  <= 2'((data_in % 32'd360) / 32'd90);
      exp_valid <= 1'b1;
    end else begin
      exp_valid <= 1'b0;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_on) begin
      vectors++;
      if (data_out !== exp_data || quadrant !== exp_quad || valid_out !== exp_valid) begin
        miscompares++;
        $display("FAIL model: got data=%0d q=%0d v=%0b, expected data=%0d q=%0d v=%0b (t=%0t)",
                 data_out, quadrant, valid_out, exp_data, exp_quad, exp_valid, $time);
      end
    end
  end

  // Drive one cycle of inputs, then land just after the edge that consumes them.
  task automatic step(input logic rst, input logic en, input logic [31:0] d);
    reset_n    = rst;
    en_divider = en;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] d,
                           input logic [1:0] q, input logic v);
    vectors++;
    if (data_out !== d || quadrant !== q || valid_out !== v) begin
      miscompares++;
      $display("FAIL %s: got data=%0d q=%0d v=%0b, expected data=%0d q=%0d v=%0b",
               name, data_out, quadrant, valid_out, d, q, v);
    end
  endtask

  logic [31:0] edge_in  [10];
  logic [31:0] edge_out [10];
  logic [1:0]  edge_q   [10];

  initial begin
    edge_in  = '{0, 89, 90, 179, 180, 270, 359, 360, 1000, 32'hFFFF_FFFF};
    edge_out = '{0, 89, 90, 179, 180, 270, 359, 0,   280,  255};
    edge_q   = '{0, 0,  1,  1,   2,   3,   3,   0,   3,    2};

    // Reset held with a live operand on the inputs.
    step(1'b1, 1'b1, 32'd725);
    check_on = 1'b1;
    check_lit("reset_hold0", 32'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 32'd725);
    check_lit("reset_hold1", 32'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 32'd725);
    check_lit("first_after_reset", 32'd5, 2'd0, 1'b1);

    // Quadrant edges, wrap and maximum input, back to back.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, edge_in[i]);
      check_lit($sformatf("edge_%0d", edge_in[i]), edge_out[i], edge_q[i], 1'b1);
    end

    // Random operands; the model compare covers these.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, $urandom);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, ($urandom_range(0, 1) == 1), $urandom);
    end

    // Enable gating: outputs hold, valid drops.
    step(1'b0, 1'b1, 32'd450);
    check_lit("gate_load", 32'd90, 2'd1, 1'b1);
    step(1'b0, 1'b0, 32'd100);
    check_lit("gate_hold0", 32'd90, 2'd1, 1'b0);
    step(1'b0, 1'b0, 32'd200);
    check_lit("gate_hold1", 32'd90, 2'd1, 1'b0);
    step(1'b0, 1'b0, 32'd300);
    check_lit("gate_hold2", 32'd90, 2'd1, 1'b0);
    step(1'b0, 1'b1, 32'd200);
    check_lit("gate_reenable", 32'd200, 2'd2, 1'b1);

    // Mid-stream reset discards the in-flight operand.
    step(1'b0, 1'b1, 32'd10);
    check_lit("stream_10", 32'd10, 2'd0, 1'b1);
    step(1'b0, 1'b1, 32'd100);
    check_lit("stream_100", 32'd100, 2'd1, 1'b1);
    step(1'b1, 1'b1, 32'd200);
    check_lit("midstream_reset", 32'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 32'd300);
    check_lit("after_midstream", 32'd300, 2'd3, 1'b1);

    step(1'b0, 1'b0, 32'd0);
    check_lit("final_idle", 32'd300, 2'd3, 1'b0);
    @(negedge clk);
    check_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
